// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Front-end hazard controller for the fetch/decode stages. Arbitrates three
// stall/flush sources with priority branch > instruction-cache miss > load-use
// and drives the enables for the fetch PC register, the IF/ID register and the
// control-unit path into ID/EX.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   if_hit        fetch hit bit for the instruction being fetched
//   branch_taken  PCSrc, branch resolved taken this cycle
//   id_rs, id_rt  source register fields of the instruction in IF/ID
//   id_uses_rt    instruction in ID reads rt
//   ex_mem_read   instruction in EX is a load
//   ex_rt         destination register of the load in EX
//   pc_write      enable for the fetch PC register
//   if_id_write   enable for the IF/ID register
//   if_id_flush   load a NOP into IF/ID when if_id_write=1
//   id_ex_bubble  force all ID/EX control bits to 0
//   refill_req    one-cycle pulse requesting a cache line refill
//   refill_busy   high while the refill countdown is running
//   stall_cycles  saturating count of non-reset cycles with pc_write=0
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MISS_PENALTY = 4,   // REFILL cycles after miss detection, 1..255
    parameter int REG_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_hit,
    input  logic             branch_taken,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             refill_req,
    output logic             refill_busy,
    output logic [15:0]      stall_cycles
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] stall_q, stall_d;
    logic        lu;

    // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign lu = ex_mem_read && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        // NOTE: every output and next-state signal gets a default first so no
        // path through the case leaves it unassigned and infers a latch.
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        refill_req   = 1'b0;
        refill_busy  = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;

        if (rst) begin
            // Hold fetch and feed NOPs/bubbles downstream while in reset.
            pc_write     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (branch_taken) begin
            // Redirect wins over everything, and also aborts any refill.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = ST_RUN;
            if (state_q == ST_REFILL) begin
                cnt_d = 8'd0;
            end
        end else if (state_q == ST_REFILL || !if_hit) begin
            // Fetch is stalled on the cache. The instruction in ID either holds
            // behind a load-use hazard or advances and is replaced by a NOP.
            pc_write = 1'b0;
            if (lu) begin
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end else begin
                if_id_flush  = 1'b1;
            end

            if (state_q == ST_RUN) begin
                refill_req = 1'b1;
                state_d    = ST_REFILL;
                cnt_d      = 8'(MISS_PENALTY);
            end else begin
                refill_busy = 1'b1;
                cnt_d       = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = ST_RUN;
                end
            end
        end else if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Reset cycles are excluded; the count saturates instead of wrapping.
    always_comb begin
        stall_d = stall_q;
        if (!rst && !pc_write && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 8'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed bench for pipeline_hazard_ctrl with MISS_PENALTY=4. Inputs change
// on the falling edge; combinational outputs are sampled 1 ns later, so the
// registered state seen is the one from the preceding rising edge.
// Output vectors are packed as {pc_write, if_id_write, if_id_flush,
// id_ex_bubble, refill_req, refill_busy}.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 5;

    localparam logic [5:0] V_RESET   = 6'b011100;
    localparam logic [5:0] V_NORMAL  = 6'b110000;
    localparam logic [5:0] V_LU      = 6'b000100;
    localparam logic [5:0] V_MISS    = 6'b011010;
    localparam logic [5:0] V_MISS_LU = 6'b000110;
    localparam logic [5:0] V_REFILL  = 6'b011001;
    localparam logic [5:0] V_BRANCH  = 6'b111100;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_hit;
    logic             branch_taken;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rt;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             refill_req;
    logic             refill_busy;
    logic [15:0]      stall_cycles;

    int checks   = 0;
    int failures = 0;
    int exp_stall = 0;

    pipeline_hazard_ctrl #(
        .MISS_PENALTY(4),
        .REG_W       (REG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_hit      (if_hit),
        .branch_taken(branch_taken),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .if_id_flush (if_id_flush),
        .id_ex_bubble(id_ex_bubble),
        .refill_req  (refill_req),
        .refill_busy (refill_busy),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [5:0] exp);
        check(tag, 32'({pc_write, if_id_write, if_id_flush, id_ex_bubble,
                        refill_req, refill_busy}), 32'(exp));
    endtask

    // Apply one cycle of inputs at the falling edge and let them settle.
    task automatic drive(input logic r, input logic hit, input logic br,
                         input logic mr, input int ert, input int rs,
                         input int rt, input logic urt);
        @(negedge clk);
        rst          = r;
        if_hit       = hit;
        branch_taken = br;
        ex_mem_read  = mr;
        ex_rt        = REG_W'(ert);
        id_rs        = REG_W'(rs);
        id_rt        = REG_W'(rt);
        id_uses_rt   = urt;
        #1;
    endtask

    initial begin
        int pulses;

        rst = 1'b1; if_hit = 1'b1; branch_taken = 1'b0; ex_mem_read = 1'b0;
        ex_rt = '0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;

        // Reset held for two cycles.
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        check_outs("reset_outs", V_RESET);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        check_outs("reset_outs2", V_RESET);

        drive(0, 1, 0, 0, 0, 1, 2, 0);
        check_outs("post_reset", V_NORMAL);
        check("post_reset_stall", 32'(stall_cycles), 0);

        // Load-use on rs: one stall cycle, then the bubble reaches EX.
        drive(0, 1, 0, 1, 5, 5, 2, 0);
        check_outs("lu_rs", V_LU);
        exp_stall++;
        drive(0, 1, 0, 0, 0, 5, 2, 0);
        check_outs("lu_rs_after", V_NORMAL);
        check("lu_rs_stall", 32'(stall_cycles), 32'(exp_stall));

        // Load into register 0 never stalls.
        drive(0, 1, 0, 1, 0, 0, 0, 1);
        check_outs("lu_r0", V_NORMAL);

        // rt match only counts when the ID instruction reads rt.
        drive(0, 1, 0, 1, 7, 3, 7, 0);
        check_outs("lu_rt_unused", V_NORMAL);
        drive(0, 1, 0, 1, 7, 3, 7, 1);
        check_outs("lu_rt_used", V_LU);
        exp_stall++;
        drive(0, 1, 0, 0, 0, 3, 7, 1);
        check("lu_rt_stall", 32'(stall_cycles), 32'(exp_stall));

        // Single-cycle miss: 1 detect cycle + 4 REFILL cycles.
        pulses = 0;
        drive(0, 0, 0, 0, 0, 1, 2, 0);
        check_outs("miss_detect", V_MISS);
        pulses += int'(refill_req);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 0, 1, 2, 0);
            check_outs($sformatf("refill_%0d", i), V_REFILL);
            pulses += int'(refill_req);
        end
        exp_stall += 5;
        drive(0, 1, 0, 0, 0, 1, 2, 0);
        check_outs("refill_done", V_NORMAL);
        check("refill_pulses", 32'(pulses), 1);
        check("miss_stall", 32'(stall_cycles), 32'(exp_stall));

        // Branch in the second REFILL cycle aborts the refill.
        drive(0, 0, 0, 0, 0, 1, 2, 0);
        check_outs("abort_detect", V_MISS);
        drive(0, 1, 0, 0, 0, 1, 2, 0);
        check_outs("abort_refill1", V_REFILL);
        drive(0, 1, 1, 1, 4, 4, 2, 0);
        check_outs("abort_branch", V_BRANCH);
        exp_stall += 2;
        drive(0, 1, 0, 0, 0, 1, 2, 0);
        check_outs("abort_run", V_NORMAL);
        check("abort_stall", 32'(stall_cycles), 32'(exp_stall));

        // Miss and load-use together, then lu clears during REFILL.
        drive(0, 0, 0, 1, 3, 3, 2, 0);
        check_outs("miss_lu", V_MISS_LU);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 0, 3, 2, 0);
            check_outs($sformatf("miss_lu_refill_%0d", i), V_REFILL);
        end
        exp_stall += 5;
        drive(0, 1, 0, 0, 0, 3, 2, 0);
        check_outs("miss_lu_done", V_NORMAL);
        check("miss_lu_stall", 32'(stall_cycles), 32'(exp_stall));

        // Load-use during REFILL holds IF/ID instead of flushing.
        drive(0, 0, 0, 0, 0, 1, 2, 0);
        drive(0, 1, 0, 1, 6, 6, 2, 0);
        check_outs("refill_lu", 6'b000101);

        // Reset mid-refill aborts without a refill request.
        drive(1, 1, 0, 0, 0, 1, 2, 0);
        check_outs("reset_mid_refill", V_RESET);
        drive(0, 1, 0, 0, 0, 1, 2, 0);
        check_outs("after_reset_refill", V_NORMAL);
        check("after_reset_stall", 32'(stall_cycles), 0);

        // Continuous miss drives the counter into saturation.
        drive(0, 0, 0, 0, 0, 1, 2, 0);
        repeat (65540) @(posedge clk);
        #1;
        check("stall_saturated", 32'(stall_cycles), 32'h0000FFFF);
        check("sat_pc_write", 32'(pc_write), 0);
        @(posedge clk);
        #1;
        check("stall_held", 32'(stall_cycles), 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
